// File: rtl/mips32_mem_dumper_pkg.sv
// Shared definitions for the MIPS32 data-memory dumper: FSM encodings and word geometry.
package mips32_mem_dumper_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_CNT_W  = 11;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_SEND  = 3'd3,
    S_CKSUM = 3'd4,
    S_FIN   = 3'd5
  } state_t;

endpackage

// File: rtl/mips32_mem_dumper_serializer.sv
// Word-to-byte serializer: loads a 32-bit word and emits it MSB-first over valid/ready.
// With single=1 only the top byte is emitted (used for the trailing checksum byte).
module mips32_word_serializer
  import mips32_mem_dumper_pkg::*;
(
  input  logic        clk1,
  input  logic        rst,
  input  logic        load,
  input  logic        single,
  input  logic [31:0] word,
  input  logic        ready,
  output logic        valid,
  output logic [7:0]  data,
  output logic        last
);

  localparam int IDX_W = $clog2(WORD_BYTES);

  logic [31:0]      sh;
  logic [IDX_W-1:0] left;

  // Shifting zeros in on every accept leaves data at 0 once the word is drained.
  always_ff @(posedge clk1) begin
    if (rst) begin
      sh    <= '0;
      left  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      sh    <= word;
      valid <= 1'b1;
      left  <= single ? '0 : IDX_W'(WORD_BYTES - 1);
    end else if (valid && ready) begin
      sh <= {sh[23:0], 8'h00};
      if (left == '0) valid <= 1'b0;
      else            left  <= left - IDX_W'(1);
    end
  end

  assign data = sh[31:24];
  assign last = valid && (left == '0);

endmodule

// File: rtl/mips32_mem_dumper.sv
// Data-memory readback engine: reads count words from a synchronous port and streams bytes out.
// Optional trailing XOR checksum byte enabled by defining MIPS32_DUMP_CKSUM_EN.
module mips32_mem_dumper
  import mips32_mem_dumper_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic [2:0]        dbg_state
);

  // Byte link: a byte transfers on a rising edge where out_valid && out_ready; out_valid and
  // out_data are registered, never depend on out_ready, and hold while the sink stalls.
  state_t            state;
  logic [CNT_W-1:0]  remaining;
  logic              fire;
  logic              ser_load;
  logic              ser_single;
  logic              ser_last;
  logic [31:0]       ser_word;

  assign fire      = out_valid && out_ready;
  assign dbg_state = state;

`ifdef MIPS32_DUMP_CKSUM_EN
  logic [7:0] cksum;
  logic       ck_load;

  // The checksum byte is loaded on the same edge the final data byte is accepted.
  assign ck_load    = (state == S_SEND) && fire && ser_last && (remaining == CNT_W'(1));
  assign ser_load   = (state == S_WAIT) || ck_load;
  assign ser_single = ck_load;
  assign ser_word   = ck_load ? {cksum ^ out_data, 24'h000000} : mem_rd_data;

  always_ff @(posedge clk1) begin
    if (rst)                               cksum <= '0;
    else if (state == S_IDLE && start)     cksum <= '0;
    else if (state == S_SEND && fire)      cksum <= cksum ^ out_data;
  end
`else
  assign ser_load   = (state == S_WAIT);
  assign ser_single = 1'b0;
  assign ser_word   = mem_rd_data;
`endif

  mips32_word_serializer u_ser (
    .clk1   (clk1),
    .rst    (rst),
    .load   (ser_load),
    .single (ser_single),
    .word   (ser_word),
    .ready  (out_ready),
    .valid  (out_valid),
    .data   (out_data),
    .last   (ser_last)
  );

  always_ff @(posedge clk1) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      remaining <= '0;
    end else begin
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            remaining <= count;
            mem_addr  <= base_addr;
            if (count == '0) begin
              state <= S_FIN;
            end else begin
              state     <= S_READ;
              mem_rd_en <= 1'b1;
            end
          end
        end
        S_READ: state <= S_WAIT;
        S_WAIT: state <= S_SEND;
        S_SEND: begin
          if (fire && ser_last) begin
            if (remaining == CNT_W'(1)) begin
`ifdef MIPS32_DUMP_CKSUM_EN
              state <= S_CKSUM;
`else
              state <= S_FIN;
`endif
            end else begin
              remaining <= remaining - CNT_W'(1);
              mem_addr  <= mem_addr + ADDR_W'(1);
              mem_rd_en <= 1'b1;
              state     <= S_READ;
            end
          end
        end
`ifdef MIPS32_DUMP_CKSUM_EN
        S_CKSUM: if (fire) state <= S_FIN;
`endif
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_mem_dumper.sv
// Self-checking bench for mips32_mem_dumper; honours MIPS32_DUMP_CKSUM_EN for the checksum byte.
module tb_mips32_mem_dumper;

  localparam int ADDR_W    = 10;
  localparam int CNT_W     = 11;
  localparam int MEM_WORDS = 1 << ADDR_W;
`ifdef MIPS32_DUMP_CKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic              clk1;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  count;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic [2:0]        dbg_state;

  logic [31:0] mem [0:MEM_WORDS-1];
  logic [7:0]  exp_q[$];
  int checks;
  int errors;

  int obs_first_rd, obs_first_valid, obs_done_k, obs_last_k;
  int obs_busy_cnt, obs_rd_cnt, obs_nbytes;
  logic [ADDR_W-1:0] obs_addrs[$];

  // Clock / reset
  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  mips32_mem_dumper #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk1        (clk1),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .dbg_state   (dbg_state)
  );

  // Synchronous memory: data one cycle after the read strobe
  always @(posedge clk1) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  // Reference model: big-endian byte stream of the words, plus XOR of all bytes when enabled
  function automatic void build_expected(input int b, input int c);
    logic [31:0] w;
    logic [7:0]  bt;
    logic [7:0]  ck;
    exp_q.delete();
    ck = 8'h00;
    for (int i = 0; i < c; i++) begin
      w = mem[(b + i) % MEM_WORDS];
      for (int j = 3; j >= 0; j--) begin
        bt = w[8*j +: 8];
        exp_q.push_back(bt);
        ck = ck ^ bt;
      end
    end
    if (CK == 1 && c > 0) exp_q.push_back(ck);
  endfunction

  // Driver + sink: k counts cycles after the edge that sampled start (k=1 is the next cycle)
  task automatic run_dump(input int b, input int c, input int mode, input int mid_start_k,
                          input int stop_after);
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [7:0] e;
    int         limit;
    bit         finished;
    build_expected(b, c);
    obs_first_rd = -1; obs_first_valid = -1; obs_done_k = -1; obs_last_k = -1;
    obs_busy_cnt = 0; obs_rd_cnt = 0; obs_nbytes = 0;
    obs_addrs.delete();
    base_addr = ADDR_W'(b);
    count     = CNT_W'(c);
    start     = 1'b1;
    tick();
    start = 1'b0;
    limit = c * 60 + 60;
    finished = 1'b0;
    prev_stall = 1'b0;
    prev_data = 8'h00;
    for (int k = 1; k <= limit && !finished; k++) begin
      if (mem_rd_en) begin
        obs_rd_cnt++;
        obs_addrs.push_back(mem_addr);
        if (obs_first_rd < 0) obs_first_rd = k;
      end
      if (out_valid && obs_first_valid < 0) obs_first_valid = k;
      if (busy) obs_busy_cnt++;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          errors++;
          $display("FAIL hold k=%0d: valid=%b data=%h, required valid=1 data=%h",
                   k, out_valid, out_data, prev_data);
        end
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (k % 2) == 1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_byte k=%0d: got %h, required no further byte", k, out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL byte%0d k=%0d: got %h, required %h", obs_nbytes, k, out_data, e);
          end
        end
        obs_nbytes++;
        obs_last_k = k;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (done) begin
        obs_done_k = k;
        finished = 1'b1;
      end else if (stop_after > 0 && obs_nbytes == stop_after) begin
        finished = 1'b1;
      end else begin
        start = (k == mid_start_k);
        tick();
      end
    end
    start = 1'b0;
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done within %0d cycles (base=%0d count=%0d)", limit, b, c);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = '0; count = '0;
    tick(); tick();
    checks++;
    if ({busy, done, mem_rd_en, out_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/rd_en/valid=%b, required 0000",
               {busy, done, mem_rd_en, out_valid});
    end
    checks++;
    if (mem_addr !== '0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: addr=%0d data=%h, required 0 00", mem_addr, out_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    run_dump(120, 2, 0, 0, 0);
    checks++;
    if (exp_q.size() != 0 || obs_nbytes != 8 + CK) begin
      errors++;
      $display("FAIL basic_count: bytes=%0d left=%0d, required %0d 0", obs_nbytes, exp_q.size(), 8 + CK);
    end
    checks++;
    if (obs_first_rd != 1 || obs_first_valid != 3) begin
      errors++;
      $display("FAIL latency: rd_en at %0d valid at %0d, required 1 3", obs_first_rd, obs_first_valid);
    end
    checks++;
    if (obs_last_k != 12 + CK) begin
      errors++;
      $display("FAIL throughput: last byte at %0d, required %0d", obs_last_k, 12 + CK);
    end
    checks++;
    if (obs_done_k != obs_last_k + 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_timing: done at %0d busy=%b, required %0d 0", obs_done_k, busy, obs_last_k + 2);
    end
  endtask

  task automatic test_backpressure();
    run_dump(120, 2, 1, 0, 0);
    checks++;
    if (exp_q.size() != 0 || obs_nbytes != 8 + CK) begin
      errors++;
      $display("FAIL bp_count: bytes=%0d left=%0d, required %0d 0", obs_nbytes, exp_q.size(), 8 + CK);
    end
  endtask

  task automatic test_wrap();
    mem[MEM_WORDS-1] = $urandom;
    mem[0]           = $urandom;
    run_dump(MEM_WORDS - 1, 2, 0, 0, 0);
    checks++;
    if (obs_addrs.size() != 2) begin
      errors++;
      $display("FAIL wrap_reads: %0d reads, required 2", obs_addrs.size());
    end else if (obs_addrs[0] !== ADDR_W'(MEM_WORDS - 1) || obs_addrs[1] !== '0) begin
      errors++;
      $display("FAIL wrap_addr: %0d then %0d, required %0d then 0", obs_addrs[0], obs_addrs[1], MEM_WORDS - 1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_bytes: %0d bytes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_zero_count();
    run_dump(120, 0, 0, 0, 0);
    checks++;
    if (obs_rd_cnt != 0 || obs_first_valid != -1) begin
      errors++;
      $display("FAIL zero_access: reads=%0d first_valid=%0d, required 0 -1", obs_rd_cnt, obs_first_valid);
    end
    checks++;
    if (obs_done_k != 2 || obs_busy_cnt != 1) begin
      errors++;
      $display("FAIL zero_timing: done at %0d busy cycles %0d, required 2 1", obs_done_k, obs_busy_cnt);
    end
  endtask

  task automatic test_mid_start();
    run_dump(120, 2, 0, 7, 0);
    checks++;
    if (obs_nbytes != 8 + CK || obs_rd_cnt != 2) begin
      errors++;
      $display("FAIL mid_start: bytes=%0d reads=%0d, required %0d 2", obs_nbytes, obs_rd_cnt, 8 + CK);
    end
    // start raised during the final busy cycle must not launch another dump
    run_dump(120, 1, 0, 7 + CK, 0);
    tick();
    checks++;
    if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL fin_start: busy=%b rd_en=%b, required 0 0", busy, mem_rd_en);
    end
  endtask

  task automatic test_reset_mid();
    run_dump(120, 2, 0, 0, 5);
    rst = 1'b1;
    tick();
    checks++;
    if ({busy, done, mem_rd_en, out_valid} !== 4'b0000 || mem_addr !== '0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: busy/done/rd/valid=%b addr=%0d data=%h, required 0000 0 00",
               {busy, done, mem_rd_en, out_valid}, mem_addr, out_data);
    end
    rst = 1'b0;
    run_dump(120, 1, 0, 0, 0);
    checks++;
    if (exp_q.size() != 0 || obs_nbytes != 4 + CK) begin
      errors++;
      $display("FAIL fresh_dump: bytes=%0d left=%0d, required %0d 0", obs_nbytes, exp_q.size(), 4 + CK);
    end
  endtask

  task automatic test_random();
    int b;
    int c;
    for (int it = 0; it < 8; it++) begin
      b = $urandom_range(0, MEM_WORDS - 1);
      c = $urandom_range(1, 5);
      for (int i = 0; i < c; i++) mem[(b + i) % MEM_WORDS] = $urandom;
      run_dump(b, c, 2, 0, 0);
      checks++;
      if (exp_q.size() != 0 || obs_rd_cnt != c) begin
        errors++;
        $display("FAIL rand%0d: left=%0d reads=%0d, required 0 %0d", it, exp_q.size(), obs_rd_cnt, c);
      end
      for (int i = 0; i < obs_addrs.size() && i < c; i++) begin
        checks++;
        if (obs_addrs[i] !== ADDR_W'((b + i) % MEM_WORDS)) begin
          errors++;
          $display("FAIL rand%0d_addr%0d: %0d, required %0d", it, i, obs_addrs[i], (b + i) % MEM_WORDS);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0;
    mem[120] = 32'd85;
    mem[121] = 32'd130;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_count();
    test_mid_start();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
